// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Package  : io_pkg
// Brief    : Shared types and constants for the output-port serial path.
// Revision : 1.0
// ============================================================================
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/out_port_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Interface : out_port_uart_tx_if
// Brief     : Core output-port strobe/data plus serial line and status flags.
// Revision  : 1.0
// ============================================================================
interface out_port_uart_tx_if;
    import io_pkg::*;

    logic [UART_DATA_BITS-1:0] Data_in;
    logic                      Out_En;
    logic                      TX;
    logic                      Busy;
    logic                      Full;
    logic                      Overflow;

    modport master (
        output Data_in, Out_En,
        input  TX, Busy, Full, Overflow
    );

    modport slave (
        input  Data_in, Out_En,
        output TX, Busy, Full, Overflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, first-word-fall-through, registered count/flags.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int              c_ptr_w      = $clog2(DEPTH);
    localparam int              c_cnt_w      = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count_next;

    // Requests are qualified against the registered flags only.
    assign w_push = push && !r_full;
    assign w_pop  = pop  && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_full_count);
            r_empty <= (w_count_next == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/out_port_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : out_port_uart_tx
// Brief    : Buffers core OUT bytes and sends them as contiguous 8N1 frames.
// Revision : 1.0
// ============================================================================
module out_port_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    out_port_uart_tx_if.slave  bus
);

    localparam int                 c_tmr_w      = $clog2(CLKS_PER_BIT);
    localparam int                 c_idx_w      = $clog2(UART_DATA_BITS);
    localparam int                 c_cnt_w      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_tmr_w-1:0] c_bit_last   = c_tmr_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(UART_DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(FIFO_DEPTH);

    tx_state_t                 r_state;
    logic [c_tmr_w-1:0]        r_timer;
    logic [c_idx_w-1:0]        r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_overflow;

    logic [UART_DATA_BITS-1:0] w_dout;
    logic [c_cnt_w-1:0]        w_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_bit_done;

    assign w_bit_done = (r_timer == c_bit_last);
    assign w_push     = bus.Out_En && !w_full;
    // Head is consumed either from idle or on the last stop cycle (no gap).
    assign w_pop      = !w_empty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (bus.Out_En),
        .pop   (w_pop),
        .din   (bus.Data_in),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= UART_IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.Out_En && (w_count == c_full_count)) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (!w_empty) begin
                        r_shift <= w_dout;
                        r_tx    <= ~UART_IDLE_LEVEL;
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_tx    <= UART_IDLE_LEVEL;
                        r_busy  <= w_push;
                    end
                end
                START: begin
                    r_busy <= 1'b1;
                    if (w_bit_done) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                DATA: begin
                    r_busy <= 1'b1;
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == c_idx_last) begin
                            r_tx    <= UART_IDLE_LEVEL;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_idx_w'(1);
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (!w_empty) begin
                            r_shift <= w_dout;
                            r_tx    <= ~UART_IDLE_LEVEL;
                            r_state <= START;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= w_push;
                        end
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    assign bus.TX       = r_tx;
    assign bus.Busy     = r_busy;
    assign bus.Full     = w_full;
    assign bus.Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_out_port_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_port_uart_tx
// Brief    : Scenario bench for out_port_uart_tx against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_out_port_uart_tx;

    localparam int C     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;

    typedef logic [7:0] bq_t[$];

    logic CLK = 1'b0;
    logic RST = 1'b1;

    out_port_uart_tx_if bus();

    out_port_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of waiting bytes plus the frame on the line and its age in cycles.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_el     = 0;
    logic [7:0] m_cur    = 8'h00;
    bit         m_ovf    = 1'b0;
    bit         obs_tx[$];

    function automatic logic m_tx();
        if (!m_active)      return 1'b1;
        if (m_el < C)       return 1'b0;
        if (m_el < 9 * C)   return m_cur[(m_el - C) / C];
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_vec();
        return {m_tx(), (m_active || m_q.size() > 0), (m_q.size() == D), m_ovf};
    endfunction

    function automatic logic [3:0] dut_vec();
        return {bus.TX, bus.Busy, bus.Full, bus.Overflow};
    endfunction

    // Recover bytes from the sampled line by mid-bit sampling after each start bit.
    function automatic bq_t decode();
        bq_t r;
        int  i = 0;
        while (i + 9 * C + C / 2 < obs_tx.size()) begin
            if (obs_tx[i] == 1'b0) begin
                logic [7:0] b;
                for (int k = 0; k < 8; k++) b[k] = obs_tx[i + C + k * C + C / 2];
                r.push_back(b);
                i += 9 * C + C / 2;
            end else begin
                i++;
            end
        end
        return r;
    endfunction

    task automatic step(input logic en, input logic [7:0] d, input logic r);
        int pre;
        bus.Out_En  = en;
        bus.Data_in = d;
        RST         = r;
        @(posedge CLK);
        if (r) begin
            m_q.delete();
            m_active = 1'b0;
            m_el     = 0;
            m_ovf    = 1'b0;
        end else begin
            pre = m_q.size();
            if (en && pre >= D) m_ovf = 1'b1;
            if (m_active) begin
                m_el++;
                if (m_el == FRAME) begin
                    if (pre > 0) begin
                        m_cur = m_q.pop_front();
                        m_el  = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (pre > 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_el     = 0;
            end
            if (en && pre < D) m_q.push_back(d);
        end
        #1;
        obs_tx.push_back(bus.TX);
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
        obs_tx.delete();
    endtask

    task automatic test_reset();
        bus.Out_En = 1'b1;
        bus.Data_in = 8'h5A;
        for (int k = 0; k < 3; k++) step(1'b1, 8'h5A, 1'b1);
        n_checks++;
        if (dut_vec() !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_values: TX/Busy/Full/Ovf got %b need %b", dut_vec(), 4'b1000);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'($urandom), 1'b0);
            n_checks++;
            if (bus.TX !== 1'b1 || bus.Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: TX=%b Busy=%b need TX=1 Busy=0", k, bus.TX, bus.Busy);
            end
        end
    endtask

    task automatic test_single_byte();
        bq_t got;
        int  busy_drop = -1;
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            step(1'b0, 8'($urandom), 1'b0);
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL single_byte cyc %0d: TX/Busy/Full/Ovf got %b need %b", k, dut_vec(), m_vec());
            end
            if (busy_drop < 0 && bus.Busy === 1'b0) busy_drop = k;
        end
        n_checks++;
        if (busy_drop != 41) begin
            n_fail++;
            $display("FAIL single_busy_drop: got %0d cycles need 41", busy_drop);
        end
        got = decode();
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_line: got %p need '{a5}", got);
        end
    endtask

    task automatic test_back_to_back();
        bq_t got;
        int  i0 = -1;
        do_reset();
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 90; k++) begin
            step(1'b0, 8'($urandom), 1'b0);
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: TX/Busy/Full/Ovf got %b need %b", k, dut_vec(), m_vec());
            end
        end
        for (int i = 0; i < obs_tx.size() && i0 < 0; i++) if (obs_tx[i] == 1'b0) i0 = i;
        n_checks++;
        if (i0 < 0 || i0 + FRAME >= obs_tx.size() ||
            obs_tx[i0 + FRAME - 1] != 1'b1 || obs_tx[i0 + FRAME] != 1'b0) begin
            n_fail++;
            $display("FAIL b2b_contiguous: first start at %0d, no start bit exactly %0d cycles later", i0, FRAME);
        end
        got = decode();
        n_checks++;
        if (got.size() != 2 || got[0] !== 8'h00 || got[1] !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_line: got %p need '{00,ff}", got);
        end
    endtask

    task automatic test_overflow();
        bq_t got;
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            step(1'b1, 8'(n), 1'b0);
            if (n == 5) begin
                n_checks++;
                if (bus.Full !== 1'b1 || bus.Overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full_after5: Full=%b Ovf=%b need Full=1 Ovf=0", bus.Full, bus.Overflow);
                end
            end
        end
        n_checks++;
        if (bus.Overflow !== 1'b1 || bus.Full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after6: Full=%b Ovf=%b need Full=1 Ovf=1", bus.Full, bus.Overflow);
        end
        for (int k = 0; k < 5 * FRAME + 20; k++) begin
            step(1'b0, 8'($urandom), 1'b0);
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL ovf_drain cyc %0d: TX/Busy/Full/Ovf got %b need %b", k, dut_vec(), m_vec());
            end
        end
        got = decode();
        n_checks++;
        if (got.size() != 5 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03 ||
            got[3] !== 8'h04 || got[4] !== 8'h05) begin
            n_fail++;
            $display("FAIL ovf_line: got %p need '{01,02,03,04,05}", got);
        end
    endtask

    task automatic test_simultaneous();
        bq_t        got;
        bq_t        want;
        logic [7:0] b;
        bit         found;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            want.push_back(b);
            step(1'b1, b, 1'b0);
        end
        for (int pass = 0; pass < 2; pass++) begin
            found = 1'b0;
            for (int k = 0; k < 2 * FRAME && !found; k++) begin
                if (m_active && m_el == FRAME - 1) found = 1'b1;
                else step(1'b0, 8'h00, 1'b0);
            end
            n_checks++;
            if (!found) begin
                n_fail++;
                $display("FAIL simul_wait%0d: final stop cycle not reached in %0d cycles", pass, 2 * FRAME);
            end
            b = 8'($urandom);
            if (pass == 1) want.push_back(b);
            step(1'b1, b, 1'b0);
            n_checks++;
            if (bus.Overflow !== 1'b1 || bus.Full !== 1'b0 || dut_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL simul_stop_write%0d: TX/Busy/Full/Ovf got %b need %b (Ovf=1 Full=0)",
                         pass, dut_vec(), m_vec());
            end
        end
        for (int k = 0; k < 5 * FRAME + 10; k++) begin
            step(1'b0, 8'h00, 1'b0);
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL simul_drain cyc %0d: TX/Busy/Full/Ovf got %b need %b", k, dut_vec(), m_vec());
            end
        end
        got = decode();
        n_checks++;
        if (got.size() != want.size() || got.size() != 6) begin
            n_fail++;
            $display("FAIL simul_line: got %p need %p", got, want);
        end else begin
            for (int i = 0; i < 6; i++) if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL simul_line[%0d]: got %h need %h", i, got[i], want[i]);
                break;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found = 1'b0;
        do_reset();
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        for (int k = 0; k < FRAME && !found; k++) begin
            if (m_active && m_cur == 8'h3C && m_el == 4 * C + 1) found = 1'b1;
            else step(1'b0, 8'h00, 1'b0);
        end
        n_checks++;
        if (!found || bus.TX !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_wait: data bit 3 found=%0d TX=%b need found=1 TX=1", found, bus.TX);
        end
        step(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (dut_vec() !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_after: TX/Busy/Full/Ovf got %b need %b", dut_vec(), 4'b1000);
        end
        for (int k = 0; k < 3 * FRAME; k++) begin
            step(1'b0, 8'h00, 1'b0);
            n_checks++;
            if (bus.TX !== 1'b1 || bus.Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet cyc %0d: TX=%b Busy=%b need TX=1 Busy=0", k, bus.TX, bus.Busy);
            end
        end
    endtask

    task automatic test_random();
        logic en;
        do_reset();
        for (int k = 0; k < 900; k++) begin
            en = (k < 600) && ($urandom_range(0, 15) < 2);
            step(en, 8'($urandom), 1'b0);
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: TX/Busy/Full/Ovf got %b need %b", k, dut_vec(), m_vec());
            end
        end
    endtask

    initial begin
        bus.Out_En  = 1'b0;
        bus.Data_in = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/out_port_uart_tx.md
# out_port_uart_tx

Serial transmitter for the processor's output port. It sits directly downstream of the core. It captures each byte the core drives on its output port during an OUT cycle into a small FIFO, then serializes the bytes as 8N1 asynchronous frames on a single TX line. The core is never stalled: bytes that arrive while the FIFO is full are dropped and flagged.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range ≥2.
- FIFO_DEPTH, default 4: byte entries buffered; power of two, ≥2.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- Data_in  in  8  byte from the core's output port (core Data_out).
- Out_En  in  1  core output-port strobe. High for one cycle per OUT instruction.
- TX  out  1  serial line; idle high.
- Busy  out  1  high while FIFO non-empty or a frame is in flight.
- Full  out  1  FIFO holds FIFO_DEPTH bytes.
- Overflow  out  1  sticky flag: at least one byte was dropped since reset.

## Operation
- **Reset values:** TX=1, Busy=0, Full=0, Overflow=0. FIFO is emptied and the FSM is in IDLE.
- **Write:**
  - A byte is accepted when Out_En=1 and the registered count < FIFO_DEPTH.
  - Out_En while count==FIFO_DEPTH drops the byte and sets Overflow. This applies even if a pop happens in the same cycle; Full is based on the registered count.
  - Overflow clears only on RST.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit timer, go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the index increments. After index 7 completes, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- **Width rules:**
  - Bit timer is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is $clog2(FIFO_DEPTH)+1 bits.
- **Simultaneous push and pop:** if count < FIFO_DEPTH, both occur and count is unchanged.
- Data_in is ignored whenever Out_En=0. The value 8'h00 is a legal payload.
- **Reset mid-frame:** the frame is aborted. TX is high from the cycle after the RST edge, and the buffered bytes are discarded.

## Timing
- **Write-to-line latency:** with the FIFO empty and the FSM in IDLE, a byte written at edge N is visible in count after edge N. The FSM pops at edge N+1, and TX is low from edge N+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles (start, 8 data, stop).
- **Back-to-back frames:** consecutive frames are contiguous, with the next start bit immediately after the last stop cycle.
- **Full:** asserts the cycle after the write that makes count==FIFO_DEPTH. It deasserts the cycle after the first pop.
- **Busy:** deasserts the cycle after the final stop cycle when the FIFO is empty.
- **Output registers:** all outputs are registered. TX is driven from a flop, so there are no glitches.

## Structure
- **Shared package `io_pkg`:**
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - Constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- **Sub-module `sync_fifo`:**
  - Parameterised width and depth.
  - Ports: push, pop, din, dout, count, full, empty.
  - Registered count; first-word-fall-through dout.
- The top level contains the FSM, bit timer, bit index, shift register and the Overflow flag.

## Test plan
Scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- **Reset:** hold RST for 3 cycles → TX=1, Busy=0, Full=0, Overflow=0; TX stays 1 with no Out_En.
- **Single byte:** write 8'hA5 → TX low from the edge after write+1. Then bits 1,0,1,0,0,1,0,1, each 4 cycles, then high for 4. Busy drops 41 cycles after the write edge.
- **Back-to-back:** write 8'h00 and 8'hFF on consecutive cycles → two contiguous 40-cycle frames with no idle gap between the stop bit and the next start bit.
- **Overflow:** issue 6 consecutive writes 8'h01..8'h06 while idle →
  - The first is popped into transmission.
  - Writes 2–5 fill the FIFO; Full=1 after the 5th.
  - The 6th is dropped and Overflow=1.
  - Line output is 01,02,03,04,05.
- **Simultaneous events:** with the FIFO full, write on the final stop cycle → byte dropped and Overflow set. With count=3, write on the final stop cycle → accepted, count stays 3.
- **Reset mid-frame:** assert RST during data bit 3 of 8'h3C with 2 bytes queued → TX=1 the cycle after, Busy=0, no further frames.
